execute: RTL
============

# execute

Execute stage of the five-stage RV32I pipeline, between the ID/EX register and the `mem` stage. It selects forwarded operands, computes the ALU result, resolves branches and jumps, and runs an iterative RV32M multiply/divide unit that stalls the front of the pipeline while busy. The EX/MEM register inside this block presents `regs_out` to `mem`.

## Interface
Parameters:
- none; widths come from `rv32i_types`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `regs_in`  in  `stage_regs`  ID/EX contents: pc, ctrl, rs1, rs2, imm, rd, valid
- `fwd_sel_rs1`, `fwd_sel_rs2`  in  2 each  operand source: 0 = register, 1 = `fwd_mem`, 2 = `fwd_wb`, 3 = register
- `fwd_mem`  in  32  MEM-stage ALU result
- `fwd_wb`  in  32  WB-stage write data
- `stall_in`  in  1  `mem` stall; EX/MEM register holds while high
- `regs_out`  out  `stage_regs`  EX/MEM register; `alu` field carries the result
- `stall_out`  out  1  EX busy; IF/ID and ID/EX must hold
- `br_taken`  out  1  redirect fetch (combinational)
- `br_target`  out  32  redirect address

## Operation
- Operand A is the forwarded rs1 or the pc, selected by `ctrl`. Operand B is the forwarded rs2 or the imm.
- ALU ops: add, sub, sll, slt, sltu, xor, srl, sra, or, and. Shift amount is B[4:0].
- Branch compare (beq/bne/blt/bge/bltu/bgeu) always uses the forwarded rs1 and rs2.
- `br_taken` = `regs_in.valid` & (jump | branch condition true).
  - Target for branches and JAL: pc + imm.
  - Target for JALR: (rs1 + imm) & ~1.
  - JAL/JALR write pc + 4 to the result.
- The forwarded rs2 is copied into `regs_out.rs2` as the store data.
- Muldiv FSM (handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU):
  - IDLE: a valid muldiv op in `regs_in` latches the forwarded operands, their signs and the op, sets count = 0, asserts `stall_out`, and goes to BUSY. Operands are latched because forwarding sources change while EX is stalled.
  - Special cases go straight from IDLE to DONE with the result preset:
    - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
    - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle, on operand magnitudes. `stall_out` = 1. After 32 steps, go to DONE.
  - DONE: apply the sign fix, drive the result, `stall_out` = 0. Go to IDLE when the EX/MEM register loads. If `stall_in` is high, stay in DONE.
  - Multiply uses a 64-bit product. MUL takes the low 32 bits; the MULH variants take the high 32 bits.
- EX/MEM register loads when ~`stall_in` & ~`stall_out`.
  - If `stall_out` = 1 and `stall_in` = 0, load a bubble (`valid` = 0, ctrl read_b/write/load_regfile cleared), so `mem` never repeats a store.
  - If `stall_in` = 1, hold regardless of `stall_out`.

## Timing
- Reset (any time, including mid-divide):
  - FSM goes to IDLE, count = 0.
  - `regs_out` = all zeros.
  - `stall_out` = 0.
  - `br_taken` and `br_target` follow `regs_in`, which is zero after the upstream reset.
- Non-muldiv ops: 1 cycle; the result appears in `regs_out` the cycle after the stage register loads.
- Muldiv ops:
  - `stall_out` is high for 33 cycles (the IDLE issue cycle plus 32 BUSY cycles).
  - The result loads at the end of the DONE cycle, which is the 34th cycle in EX.
- Special-case divides: `stall_out` is high for 1 cycle, and the result loads at the end of the 2nd cycle.
- A branch is resolved in the same cycle it is in EX. Branches never assert `stall_out`.

## Configuration
- `RV32M_EN` defined: the muldiv FSM and its datapath are built.
- `RV32M_EN` undefined:
  - No FSM or muldiv datapath.
  - `stall_out` tied to 0.
  - Muldiv ctrl is ignored and those ops produce `alu` = 0.

## Structure
- `rv32i_types` gains:
  - `alu_ops` and `branch_funct3_t` (if not already present).
  - `muldiv_op_t` enum.
  - `muldiv_state_t` {IDLE, BUSY, DONE}.
  - `localparam MULDIV_STEPS = 32`.
- One sub-module, `muldiv`: FSM plus 64-bit accumulator, instantiated only under `RV32M_EN`. ALU, compare and forwarding muxes stay inline.

## Test plan
- ADD with rs1 = 5, rs2 = 7, `fwd_sel_rs1` = 1, `fwd_mem` = 100 -> `regs_out.alu` = 107 one cycle later.
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1 -> `br_taken` = 1, `br_target` = pc + imm. The same operands with BLTU -> `br_taken` = 0.
- MULH 0x80000000 × 0x80000000 -> `stall_out` high for 33 cycles, then `alu` = 0x40000000.
  - Change `fwd_mem` mid-op: no effect on the result.
  - EX/MEM receives bubbles throughout.
- DIV 7 / 0 -> `alu` = 0xFFFFFFFF after a 1-cycle stall. REM 0x80000000 % -1 -> `alu` = 0.
- DIVU with `stall_in` held high in DONE for 3 cycles -> FSM stays in DONE and the result loads when `stall_in` drops. Assert `reset` low mid-BUSY -> IDLE, `stall_out` = 0, `regs_out` = 0.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the RV32I pipeline execute stage.
//   alu_ops          - ALU operation select
//   branch_funct3_t  - branch comparison select (RV32I funct3 encoding)
//   muldiv_op_t      - RV32M operation (RV32M funct3 encoding)
//   muldiv_state_t   - iterative multiply/divide FSM states
//   ctrl_t           - decoded control carried down the pipeline
//   stage_regs       - contents of a pipeline stage register
package rv32i_types;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ops;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } muldiv_op_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;

  localparam int MULDIV_STEPS = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_STEPS);

  typedef struct packed {
    alu_ops         alu_op;
    logic           a_pc;        // operand A is pc instead of rs1
    logic           b_imm;       // operand B is imm instead of rs2
    logic           branch;
    branch_funct3_t br_funct3;
    logic           jal;
    logic           jalr;
    logic           md_en;       // RV32M multiply/divide op
    muldiv_op_t     md_op;
    logic           read_b;
    logic           write;
    logic           load_regfile;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    ctrl_t       ctrl;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        valid;
  } stage_regs;

endpackage

// File: rtl/muldiv.sv
// muldiv: iterative RV32M multiply/divide unit (built only with RV32M_EN).
// Ports:
//   clk, reset (async, active-low)
//   start     - valid muldiv op present in EX this cycle
//   stall_in  - mem stall; result is held in DONE while high
//   op, a, b  - operation and forwarded operands (latched on issue)
//   stall     - unit busy, front of pipeline must hold
//   result    - final result, valid only in DONE (zero otherwise)
// Works on operand magnitudes: shift-add multiply or restoring divide,
// one step per cycle, with the sign applied once the steps finish.
module muldiv
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall_in,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic [31:0] result
);

  muldiv_state_t           state_q, state_d;
  logic [MULDIV_CNT_W-1:0] count_q, count_d;
  logic [63:0]             acc_q, acc_d;   // mul: {hi, lo}; div: {remainder, quotient}
  logic [31:0]             b_q, b_d;
  muldiv_op_t              op_q, op_d;
  logic                    neg_q, neg_d;   // negate product / quotient
  logic                    negr_q, negr_d; // negate remainder

  logic        a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh, div_diff;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quot, rem;

  assign a_neg    = a[31] & (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign b_neg    = b[31] & (op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
  assign a_mag    = a_neg ? (32'd0 - a) : a;
  assign b_mag    = b_neg ? (32'd0 - b) : b;
  assign is_div   = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  assign div_zero = is_div && (b == 32'd0);
  assign div_ovf  = (op inside {MD_DIV, MD_REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // keep the difference only if it did not borrow (bit 32 is the borrow).
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_next = div_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          op_d    = op;
          b_d     = b_mag;
          count_d = '0;
          if (div_zero) begin
            // Result preset; sign flags cleared so DONE passes it through.
            acc_d   = {a, 32'hFFFF_FFFF};
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            state_d = DONE;
          end else if (div_ovf) begin
            acc_d   = {32'd0, 32'h8000_0000};
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            state_d = DONE;
          end else begin
            acc_d   = {32'd0, a_mag};
            neg_d   = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        acc_d   = (op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) ? div_next : mul_next;
        count_d = count_q + 1'b1;
        if (count_q == MULDIV_CNT_W'(MULDIV_STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // EX/MEM loads whenever mem is not stalling (stall is low here).
        if (!stall_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
    end
  end

  assign prod = neg_q  ? (64'd0 - acc_q)        : acc_q;
  assign quot = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
  assign rem  = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    result = '0;
    if (state_q == DONE) begin
      case (op_q)
        MD_MUL:                        result = prod[31:0];
        MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[63:32];
        MD_DIV, MD_DIVU:               result = quot;
        default:                       result = rem;
      endcase
    end
  end

endmodule

// File: rtl/execute.sv
// execute: EX stage of the five-stage RV32I pipeline.
// Ports:
//   clk, reset (async, active-low)
//   regs_in                  - ID/EX register contents
//   fwd_sel_rs1, fwd_sel_rs2 - 0/3 register, 1 fwd_mem, 2 fwd_wb
//   fwd_mem, fwd_wb          - forwarding sources
//   stall_in                 - mem stall, EX/MEM holds while high
//   regs_out                 - EX/MEM register (alu = result, rs2 = store data)
//   stall_out                - EX busy, IF/ID and ID/EX hold
//   br_taken, br_target      - combinational fetch redirect
// Build option: define RV32M_EN to include the muldiv unit; otherwise
// muldiv ops yield alu = 0 and stall_out stays low.
module execute
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  stage_regs   regs_in,
  input  logic [1:0]  fwd_sel_rs1,
  input  logic [1:0]  fwd_sel_rs2,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  input  logic        stall_in,
  output stage_regs   regs_out,
  output logic        stall_out,
  output logic        br_taken,
  output logic [31:0] br_target
);

  logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res, ex_result, md_result;
  logic [4:0]  shamt;
  logic        md_stall, br_cond;
  stage_regs   regs_out_q, regs_out_d;

  always_comb begin
    case (fwd_sel_rs1)
      2'd1:    rs1_fwd = fwd_mem;
      2'd2:    rs1_fwd = fwd_wb;
      default: rs1_fwd = regs_in.rs1;
    endcase
    case (fwd_sel_rs2)
      2'd1:    rs2_fwd = fwd_mem;
      2'd2:    rs2_fwd = fwd_wb;
      default: rs2_fwd = regs_in.rs2;
    endcase
  end

  assign op_a  = regs_in.ctrl.a_pc  ? regs_in.pc  : rs1_fwd;
  assign op_b  = regs_in.ctrl.b_imm ? regs_in.imm : rs2_fwd;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (regs_in.ctrl.alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch compare always uses the forwarded registers, never pc/imm.
  always_comb begin
    br_cond = 1'b0;
    case (regs_in.ctrl.br_funct3)
      BR_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
      BR_BNE:  br_cond = (rs1_fwd != rs2_fwd);
      BR_BLT:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      BR_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      BR_BLTU: br_cond = (rs1_fwd <  rs2_fwd);
      BR_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken  = regs_in.valid & (regs_in.ctrl.jal | regs_in.ctrl.jalr |
                                      (regs_in.ctrl.branch & br_cond));
  assign br_target = regs_in.ctrl.jalr ? ((rs1_fwd + regs_in.imm) & ~32'd1)
                                       : (regs_in.pc + regs_in.imm);

`ifdef RV32M_EN
  muldiv u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (regs_in.valid & regs_in.ctrl.md_en),
    .stall_in (stall_in),
    .op       (regs_in.ctrl.md_op),
    .a        (rs1_fwd),
    .b        (rs2_fwd),
    .stall    (md_stall),
    .result   (md_result)
  );
`else
  assign md_stall  = 1'b0;
  assign md_result = '0;
`endif

  assign stall_out = md_stall;

  always_comb begin
    if (regs_in.ctrl.jal || regs_in.ctrl.jalr) begin
      ex_result = regs_in.pc + 32'd4;
    end else if (regs_in.ctrl.md_en) begin
      ex_result = md_result;
    end else begin
      ex_result = alu_res;
    end
  end

  always_comb begin
    regs_out_d = regs_out_q;
    if (!stall_in) begin
      regs_out_d     = regs_in;
      regs_out_d.rs2 = rs2_fwd;
      regs_out_d.alu = ex_result;
      // While EX is busy, feed mem a bubble so a store is never repeated.
      if (stall_out) begin
        regs_out_d.valid             = 1'b0;
        regs_out_d.ctrl.read_b       = 1'b0;
        regs_out_d.ctrl.write        = 1'b0;
        regs_out_d.ctrl.load_regfile = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_out_q <= '0;
    end else begin
      regs_out_q <= regs_out_d;
    end
  end

  assign regs_out = regs_out_q;

endmodule
